fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- IF-stage instruction fetch unit. Owns the program counter and issues word reads to InstructionMemory.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to the IF/ID buffer through a valid/ready handshake.
- Decouples fetch from ID-stage stalls.
- Accepts a branch redirect from the WB-stage branch OR gate and flushes all wrong-path instructions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0, PC loaded on reset.
- PC_STEP, 1, PC increment per fetch (word-addressed memory).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_rd  output  1  fetch request this cycle.
- imem_addr  output  32  fetch address; equals the internal PC.
- imem_dout  input  32  instruction word; valid exactly 1 cycle after imem_rd=1.
- redirect  input  1  branch taken (WB OR-gate output).
- redirect_pc  input  32  branch target (WB ALU or DMEM result).
- out_valid  output  1  head entry available.
- out_ready  input  1  IF/ID accepts head entry (low = ID stall).
- out_instr  output  32  head instruction; opcode in [31:28].
- out_pc  output  32  PC of head instruction.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, any time): PC=RESET_PC, FIFO empty, count=0, in-flight flag cleared, out_valid=0, out_instr=0, out_pc=0.
  - imem_rd is combinational: it is 1 in the first cycle after reset deasserts, with imem_addr=RESET_PC.
  - Any response arriving after reset is discarded.
- State:
  - pc_reg.
  - inflight bit plus inflight_pc.
  - FIFO storage with rd_ptr/wr_ptr, each wrapping modulo DEPTH.
  - count, range 0..DEPTH.
- Issue rule: imem_rd = !redirect && (count + inflight < DEPTH).
  - Conservative: a same-cycle pop is not counted.
  - On issue: inflight<=1, inflight_pc<=pc_reg, pc_reg<=pc_reg+PC_STEP (mod 2^32, so 32'hFFFFFFFF wraps to 0).
  - No issue: inflight<=0.
- Response: if inflight=1 and there is no redirect this cycle, imem_dout and inflight_pc are written at wr_ptr at the clock edge ending the cycle.
- Pop: occurs when out_valid && out_ready at the edge; rd_ptr advances.
- out_valid = (count != 0). out_instr/out_pc are the entry at rd_ptr, registered-storage read with no combinational path from imem_dout.
- Latency: request in cycle N, data in N+1, out_valid in N+2. Steady-state throughput is 1 instruction/cycle while out_ready=1.
- Simultaneous push and pop: both occur and count is unchanged. This is legal even when count=DEPTH, although the issue rule prevents a push arriving at full.
- Redirect (highest priority):
  - In redirect cycle R: no issue, no push, no pop. out_valid may be 1 but a handshake in cycle R is not a transfer.
  - At the edge ending R: FIFO cleared (count=0, ptrs=0), inflight<=0 so the pending response is dropped, pc_reg<=redirect_pc.
  - R+1: out_valid=0, imem_rd=1 with addr=redirect_pc.
  - R+3: out_valid=1, out_pc=redirect_pc.
- Back-to-back redirects: the last one wins. Each restarts the R..R+3 sequence.
- Full: with out_ready=0 held, exactly DEPTH requests are issued, then imem_rd stays 0 until a pop.
- Empty: out_valid=0; out_instr/out_pc hold their last values and are don't-care.

Test Plan:
1. Reset, then out_ready=1 with imem returning addr+32'hA0000000 → imem_addr 0,1,2,3… one per cycle; out_valid first high 2 cycles after reset release; out_pc 0,1,2,…; out_instr A0000000, A0000001, …; no gaps.
2. out_ready=0 from reset → exactly 4 requests (addr 0..3), count reaches 4, imem_rd=0 thereafter. Raise out_ready → out_pc 0,1,2,3 then 4 with no loss or duplication.
3. Full FIFO (count=4, PCs 0..3), redirect=1 with redirect_pc=32'h40 for one cycle → next cycle count=0, out_valid=0, imem_addr=32'h40; two cycles later out_pc=32'h40; PCs 0..3 never accepted.
4. Redirect to 32'h80 in the cycle a response for PC 5 is returning → PC-5 data dropped; first popped entry is 32'h80.
5. RESET_PC=32'hFFFFFFFE, out_ready=1 → out_pc sequence FFFFFFFE, FFFFFFFF, 0, 1.
6. Assert reset asynchronously (mid-cycle) with count=3 and a request in flight → outputs clear immediately; after release, the first out_pc is RESET_PC and the stale response is not enqueued.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory, redirect and IF/ID handshake signals of the fetch queue.
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    logic                     imem_rd;
    logic [31:0]              imem_addr;
    logic [31:0]              imem_dout;
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [31:0]              out_pc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output imem_rd, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_dout, redirect, redirect_pc, out_ready
    );
    modport slave (
        input  imem_rd, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_dout, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: IF-stage fetch unit; owns the PC, reads instruction memory and buffers
// fetched words with their PCs in a FIFO; a branch redirect flushes the wrong path.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          PC_STEP  = 1
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_reg, inflight_pc;
    logic          inflight;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          issue, push, pop;

    // Occupancy counts the in-flight word so a full FIFO never receives a push.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue     = !bus.redirect && (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight && !bus.redirect;
    assign pop       = (count != '0) && bus.out_ready && !bus.redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (bus.redirect) begin
            pc_reg   <= bus.redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc_reg;
                pc_reg      <= pc_reg + 32'(PC_STEP);
            end
            if (push) begin
                instr_mem[wr_ptr] <= bus.imem_dout;
                pc_mem[wr_ptr]    <= inflight_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign bus.imem_rd   = issue;
    assign bus.imem_addr = pc_reg;
    assign bus.out_valid = count != '0;
    assign bus.out_instr = instr_mem[rd_ptr];
    assign bus.out_pc    = pc_mem[rd_ptr];
    assign bus.count     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized ready/redirect traffic checked
// against a queue-based model of the fetch unit.
module tb_fetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    fetch_queue_if #(.DEPTH(4)) b0 ();
    fetch_queue_if #(.DEPTH(4)) b1 ();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(1)) u0 (
        .clock(clock), .reset(reset), .bus(b0.master));
    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFFE), .PC_STEP(1)) u1 (
        .clock(clock), .reset(reset), .bus(b1.master));

    // Instruction memory: word at address a is a + A0000000, returned one cycle later.
    always @(posedge clock) begin
        b0.imem_dout <= b0.imem_addr + 32'hA0000000;
        b1.imem_dout <= b1.imem_addr + 32'hA0000000;
    end

    // Reference model of u0: a queue of PCs, the PC counter and the pending fetch.
    logic [31:0] mq[$];
    logic [31:0] m_pc, m_ifpc;
    logic        m_infl;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete(); m_infl = 1'b0; m_pc = 32'h0; m_ifpc = 32'h0;
        end else if (b0.redirect) begin
            mq.delete(); m_infl = 1'b0; m_pc = b0.redirect_pc;
        end else begin
            automatic bit iss = (mq.size() + int'(m_infl)) < 4;
            if (mq.size() != 0 && b0.out_ready) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_ifpc);
            m_infl = iss;
            if (iss) begin m_ifpc = m_pc; m_pc = m_pc + 32'd1; end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        b0.out_ready = 1'b0; b0.redirect = 1'b0; b0.redirect_pc = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (b0.count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", b0.count); end
        tests++; if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", b0.out_valid); end
        tests++; if (b0.out_instr !== 32'h0 || b0.out_pc !== 32'h0) begin fails++; $display("FAIL reset_out got %h/%h exp 0/0", b0.out_instr, b0.out_pc); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        tests++; if (b0.imem_rd !== 1'b1 || b0.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_first_fetch got %b/%h exp 1/0", b0.imem_rd, b0.imem_addr); end
        tests++; if (b1.imem_addr !== 32'hFFFFFFFE) begin fails++; $display("FAIL reset_pc got %h exp fffffffe", b1.imem_addr); end
    endtask

    task automatic test_stream();
        b0.out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tests++; if (b0.imem_addr !== 32'(k) || b0.imem_rd !== 1'b1) begin fails++; $display("FAIL stream_addr k=%0d got %b/%h exp 1/%h", k, b0.imem_rd, b0.imem_addr, k); end
            tests++; if (b0.out_valid !== (k >= 2)) begin fails++; $display("FAIL stream_valid k=%0d got %b exp %b", k, b0.out_valid, k >= 2); end
            if (k >= 2) begin
                tests++;
                if (b0.out_pc !== 32'(k - 2) || b0.out_instr !== 32'hA0000000 + 32'(k - 2)) begin
                    fails++; $display("FAIL stream_data k=%0d got %h/%h exp %h/%h", k, b0.out_pc, b0.out_instr, k - 2, 32'hA0000000 + 32'(k - 2));
                end
            end
            step();
        end
    endtask

    task automatic test_full();
        logic [31:0] addrs[$];
        logic [31:0] got[$];
        b0.out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (b0.imem_rd) addrs.push_back(b0.imem_addr);
            step();
        end
        tests++; if (addrs.size() != 4) begin fails++; $display("FAIL full_requests got %0d exp 4", addrs.size()); end
        for (int i = 0; i < addrs.size() && i < 4; i++) begin
            tests++; if (addrs[i] !== 32'(i)) begin fails++; $display("FAIL full_addr i=%0d got %h exp %h", i, addrs[i], i); end
        end
        tests++; if (b0.count !== 3'd4 || b0.imem_rd !== 1'b0) begin fails++; $display("FAIL full_state got count=%0d rd=%b exp 4/0", b0.count, b0.imem_rd); end
        @(negedge clock);
        b0.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (b0.out_valid) got.push_back(b0.out_pc);
            step();
        end
        tests++; if (got.size() < 6) begin fails++; $display("FAIL full_drain_len got %0d exp >=6", got.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            tests++; if (got[i] !== 32'(i)) begin fails++; $display("FAIL full_drain i=%0d got %h exp %h", i, got[i], i); end
        end
    endtask

    task automatic test_redirect_full();
        logic [31:0] got[$];
        b0.out_ready = 1'b0;
        do_reset();
        repeat (8) step();
        tests++; if (b0.count !== 3'd4) begin fails++; $display("FAIL redir_full_pre got %0d exp 4", b0.count); end
        @(negedge clock);
        b0.out_ready = 1'b1; b0.redirect = 1'b1; b0.redirect_pc = 32'h40;
        #1;
        tests++; if (b0.imem_rd !== 1'b0) begin fails++; $display("FAIL redir_no_issue got %b exp 0", b0.imem_rd); end
        @(negedge clock);
        b0.redirect = 1'b0;
        #1;
        tests++; if (b0.count !== 3'd0 || b0.out_valid !== 1'b0) begin fails++; $display("FAIL redir_flush got count=%0d valid=%b exp 0/0", b0.count, b0.out_valid); end
        tests++; if (b0.imem_rd !== 1'b1 || b0.imem_addr !== 32'h40) begin fails++; $display("FAIL redir_fetch got %b/%h exp 1/40", b0.imem_rd, b0.imem_addr); end
        step();
        tests++; if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL redir_r2_valid got %b exp 0", b0.out_valid); end
        step();
        tests++; if (b0.out_valid !== 1'b1 || b0.out_pc !== 32'h40 || b0.out_instr !== 32'hA0000040) begin fails++; $display("FAIL redir_r3 got %b/%h/%h exp 1/40/a0000040", b0.out_valid, b0.out_pc, b0.out_instr); end
        for (int k = 0; k < 3; k++) begin
            if (b0.out_valid) got.push_back(b0.out_pc);
            step();
        end
        tests++; if (got.size() != 3 || got[0] !== 32'h40 || got[1] !== 32'h41 || got[2] !== 32'h42) begin fails++; $display("FAIL redir_seq got n=%0d first=%h exp 3/40", got.size(), got.size() ? got[0] : 32'hx); end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] got[$];
        logic [31:0] expv[6] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h80, 32'h81};
        b0.out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            if (k == 6) begin b0.redirect = 1'b1; b0.redirect_pc = 32'h80; #1; end
            if (k == 7) begin b0.redirect = 1'b0; #1; end
            if (b0.out_valid && !b0.redirect) got.push_back(b0.out_pc);
            step();
        end
        tests++; if (got.size() < 6) begin fails++; $display("FAIL inflight_len got %0d exp >=6", got.size()); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            tests++; if (got[i] !== expv[i]) begin fails++; $display("FAIL inflight_seq i=%0d got %h exp %h", i, got[i], expv[i]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                tests++;
                if (b1.out_valid !== 1'b1 || b1.out_pc !== 32'hFFFFFFFE + 32'(k - 2) || b1.out_instr !== b1.out_pc + 32'hA0000000) begin
                    fails++; $display("FAIL wrap k=%0d got %b/%h exp 1/%h", k, b1.out_valid, b1.out_pc, 32'hFFFFFFFE + 32'(k - 2));
                end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        b0.out_ready = 1'b0;
        do_reset();
        repeat (4) step();
        tests++; if (b0.count !== 3'd3 || b0.imem_rd !== 1'b0) begin fails++; $display("FAIL areset_pre got count=%0d rd=%b exp 3/0", b0.count, b0.imem_rd); end
        #1 reset = 1'b1;
        #1;
        tests++; if (b0.count !== 3'd0 || b0.out_valid !== 1'b0 || b0.out_pc !== 32'h0 || b0.out_instr !== 32'h0) begin fails++; $display("FAIL areset_clear got %0d/%b/%h/%h exp 0/0/0/0", b0.count, b0.out_valid, b0.out_pc, b0.out_instr); end
        tests++; if (b0.imem_addr !== 32'h0) begin fails++; $display("FAIL areset_pc got %h exp 0", b0.imem_addr); end
        #1 reset = 1'b0;
        step();
        tests++; if (b0.count !== 3'd0 || b0.out_valid !== 1'b0) begin fails++; $display("FAIL areset_stale got count=%0d valid=%b exp 0/0", b0.count, b0.out_valid); end
        step();
        tests++; if (b0.count !== 3'd1 || b0.out_pc !== 32'h0 || b0.out_instr !== 32'hA0000000) begin fails++; $display("FAIL areset_first got %0d/%h/%h exp 1/0/a0000000", b0.count, b0.out_pc, b0.out_instr); end
    endtask

    task automatic test_random();
        b0.out_ready = 1'b1; b0.redirect = 1'b0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            automatic logic exp_rd;
            @(negedge clock);
            b0.out_ready   = ($urandom_range(0, 3) != 0);
            b0.redirect    = ($urandom_range(0, 9) == 0);
            b0.redirect_pc = $urandom;
            #1;
            exp_rd = !b0.redirect && ((mq.size() + int'(m_infl)) < 4);
            tests++; if (b0.imem_rd !== exp_rd || b0.imem_addr !== m_pc) begin fails++; $display("FAIL rand_fetch k=%0d got %b/%h exp %b/%h", k, b0.imem_rd, b0.imem_addr, exp_rd, m_pc); end
            tests++; if (b0.count !== 3'(mq.size()) || b0.out_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rand_count k=%0d got %0d/%b exp %0d", k, b0.count, b0.out_valid, mq.size()); end
            if (mq.size() != 0) begin
                tests++;
                if (b0.out_pc !== mq[0] || b0.out_instr !== mq[0] + 32'hA0000000) begin
                    fails++; $display("FAIL rand_head k=%0d got %h/%h exp %h/%h", k, b0.out_pc, b0.out_instr, mq[0], mq[0] + 32'hA0000000);
                end
            end
        end
        @(negedge clock);
        b0.redirect = 1'b0;
    endtask

    initial begin
        b1.out_ready = 1'b1; b1.redirect = 1'b0; b1.redirect_pc = '0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_full();
        test_redirect_inflight();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
